// File: rtl/ram_com_rd.sv
// Layer-RAM read controller: scans addresses 0..63 across 8 layer RAMs and
// serialises each 24-bit pixel word onto 8 WS2812 lanes with shared bit timing.
module ram_com_rd #(
  parameter int T_BIT  = 438,
  parameter int T0H    = 140,
  parameter int T1H    = 280,
  parameter int T_RST  = 17500,
  parameter int RD_LAT = 2
) (
  input  logic         SCLK,
  input  logic         Rst,
  input  logic         read,
  output logic [5:0]   rdaddre,
  output logic         rd_en,
  input  logic [191:0] rd_data,
  output logic [7:0]   DOUT,
  output logic         trans,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  localparam logic [15:0] BIT_LAST   = 16'(T_BIT - 1);
  localparam logic [15:0] FETCH_LAST = 16'(RD_LAT);
  localparam logic [15:0] RST_LAST   = 16'(T_RST - 1);
  localparam logic [15:0] T0H_C      = 16'(T0H);
  localparam logic [15:0] T1H_C      = 16'(T1H);

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [5:0]       addr_q, addr_d;
  logic [7:0][23:0] sr_q, sr_d;
  logic             rd_en_q, rd_en_d;
  logic             trans_q, trans_d;
  logic             done_q, done_d;
  logic [7:0]       dout_q, dout_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    addr_d  = addr_q;
    sr_d    = sr_q;
    rd_en_d = 1'b0;
    trans_d = trans_q;
    done_d  = 1'b0;
    dout_d  = '0;

    case (state_q)
      IDLE: begin
        // The done cycle is still IDLE, but a read there must not start a frame.
        if (read && !done_q) begin
          state_d = FETCH;
          addr_d  = '0;
          cnt_d   = '0;
          rd_en_d = 1'b1;
          trans_d = 1'b1;
        end
      end
      FETCH: begin
        if (cnt_q == FETCH_LAST) begin
          sr_d    = rd_data;
          bit_d   = 5'd23;
          cnt_d   = '0;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SEND: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q != 5'd0) begin
            bit_d = bit_q - 5'd1;
            for (int i = 0; i < 8; i++) sr_d[i] = {sr_q[i][22:0], 1'b0};
          end else if (addr_q == 6'd63) begin
            state_d = LATCH;
          end else begin
            addr_d  = addr_q + 6'd1;
            rd_en_d = 1'b1;
            state_d = FETCH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LATCH: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          trans_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Lane levels are derived from next-cycle position so DOUT can be registered.
    for (int i = 0; i < 8; i++)
      dout_d[i] = (state_d == SEND) && (cnt_d < (sr_d[i][23] ? T1H_C : T0H_C));
  end

  always_ff @(posedge SCLK or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      addr_q  <= '0;
      sr_q    <= '0;
      rd_en_q <= 1'b0;
      trans_q <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      addr_q  <= addr_d;
      sr_q    <= sr_d;
      rd_en_q <= rd_en_d;
      trans_q <= trans_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  assign rdaddre = addr_q;
  assign rd_en   = rd_en_q;
  assign DOUT    = dout_q;
  assign trans   = trans_q;
  assign done    = done_q;

endmodule

// File: tb/tb_ram_com_rd.sv
// Self-checking bench for ram_com_rd: a 2-cycle-latency RAM model feeds the DUT and
// captured frames are compared cycle by cycle against a waveform model built from the pixel data.
module tb_ram_com_rd;

  localparam int T_BIT     = 10;
  localparam int T0H       = 3;
  localparam int T1H       = 7;
  localparam int T_RST     = 20;
  localparam int RD_LAT    = 2;
  localparam int NPIX      = 64;
  localparam int PIX_LEN   = RD_LAT + 1 + 24 * T_BIT;
  localparam int FRAME_LEN = NPIX * PIX_LEN + T_RST;

  logic         SCLK = 1'b0;
  logic         Rst;
  logic         read;
  logic [5:0]   rdaddre;
  logic         rd_en;
  logic [191:0] rd_data;
  logic [7:0]   DOUT;
  logic         trans;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [191:0] mem [NPIX];
  logic [191:0] ram_stage;

  logic [7:0] cap_dout  [FRAME_LEN + 1];
  logic       cap_trans [FRAME_LEN + 1];
  logic       cap_done  [FRAME_LEN + 1];
  logic       cap_rden  [FRAME_LEN + 1];
  logic [5:0] cap_addr  [FRAME_LEN + 1];

  ram_com_rd #(
    .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RST(T_RST), .RD_LAT(RD_LAT)
  ) dut (
    .SCLK(SCLK), .Rst(Rst), .read(read), .rdaddre(rdaddre), .rd_en(rd_en),
    .rd_data(rd_data), .DOUT(DOUT), .trans(trans), .done(done)
  );

  always #5 SCLK = ~SCLK;

  // Layer RAMs: data valid RD_LAT=2 cycles after the rd_en cycle.
  always @(posedge SCLK) begin
    if (rd_en) ram_stage <= mem[rdaddre];
    rd_data <= ram_stage;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_dout(int c);
    logic [7:0] v;
    int p, r, b, k;
    v = '0;
    if (c >= NPIX * PIX_LEN) return v;
    p = c / PIX_LEN;
    r = c % PIX_LEN - (RD_LAT + 1);
    if (r < 0) return v;
    b = r / T_BIT;
    k = r % T_BIT;
    for (int l = 0; l < 8; l++)
      v[l] = (k < (mem[p][24 * l + 23 - b] ? T1H : T0H));
    return v;
  endfunction

  // Counts cycles where the captured frame departs from the model; reports the first one.
  function automatic int frame_errors(output int first_c, output string detail);
    int n;
    logic [7:0] ed;
    logic et, edn, er;
    logic [5:0] ea;
    n = 0;
    first_c = -1;
    detail = "";
    for (int c = 0; c <= FRAME_LEN; c++) begin
      ed  = exp_dout(c);
      et  = (c < FRAME_LEN);
      edn = (c == FRAME_LEN);
      er  = (c < NPIX * PIX_LEN) && (c % PIX_LEN == 0);
      ea  = (c >= NPIX * PIX_LEN) ? 6'd63 : 6'(c / PIX_LEN);
      if ({cap_dout[c], cap_trans[c], cap_done[c], cap_rden[c], cap_addr[c]} !==
          {ed, et, edn, er, ea}) begin
        if (n == 0) begin
          first_c = c;
          detail = $sformatf("dout %h/%h trans %b/%b done %b/%b rd_en %b/%b addr %0d/%0d",
                             cap_dout[c], ed, cap_trans[c], et, cap_done[c], edn,
                             cap_rden[c], er, cap_addr[c], ea);
        end
        n++;
      end
    end
    return n;
  endfunction

  function automatic void fill_random();
    for (int p = 0; p < NPIX; p++)
      for (int l = 0; l < 8; l++) mem[p][24 * l +: 24] = 24'($urandom);
  endfunction

  // Caller is at a negedge. Pulses read and captures cycles 0..FRAME_LEN of the frame.
  task automatic run_frame(input int extra_read_at, input bit read_at_done);
    read = 1'b1;
    @(negedge SCLK);
    read = 1'b0;
    for (int c = 0; c <= FRAME_LEN; c++) begin
      cap_dout[c]  = DOUT;
      cap_trans[c] = trans;
      cap_done[c]  = done;
      cap_rden[c]  = rd_en;
      cap_addr[c]  = rdaddre;
      read = (c == extra_read_at) || (read_at_done && c == FRAME_LEN);
      @(negedge SCLK);
    end
  endtask

  task automatic test_reset();
    Rst  = 1'b1;
    read = 1'b0;
    #1;
    checks++;
    if ({DOUT, trans, rd_en, done, rdaddre} !== 17'd0) begin
      errors++;
      $display("FAIL reset_values: got %h expected 0", {DOUT, trans, rd_en, done, rdaddre});
    end
    repeat (3) @(negedge SCLK);
    Rst = 1'b0;
    @(negedge SCLK);
  endtask

  task automatic test_reset_mid_send();
    int busy;
    fill_random();
    read = 1'b1;
    @(negedge SCLK);
    read = 1'b0;
    repeat (500) @(negedge SCLK);
    checks++;
    if (DOUT !== exp_dout(500)) begin
      errors++;
      $display("FAIL pre_reset_dout: got %h expected %h", DOUT, exp_dout(500));
    end
    #2 Rst = 1'b1;
    #1;
    checks++;
    if ({DOUT, trans, rd_en, done} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: dout %h trans %b rd_en %b done %b expected all 0",
               DOUT, trans, rd_en, done);
    end
    repeat (2) @(negedge SCLK);
    Rst = 1'b0;
    busy = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge SCLK);
      if ({DOUT, trans, rd_en, done, rdaddre} !== 17'd0) busy++;
    end
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL idle_after_reset: %0d active cycles, expected 0", busy);
    end
  endtask

  task automatic test_single_pixel();
    int n, fc, bad;
    string d;
    logic [23:0] word;
    int hi;
    word = 24'hA500FF;
    for (int p = 0; p < NPIX; p++) mem[p] = '0;
    mem[0][23:0] = word;
    run_frame(-1, 1'b0);
    n = frame_errors(fc, d);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL single_pixel_frame: %0d bad cycles, first %0d: %s", n, fc, d);
    end
    bad = 0;
    for (int b = 0; b < 24; b++) begin
      hi = 0;
      for (int k = 0; k < T_BIT; k++) hi += int'(cap_dout[RD_LAT + 1 + b * T_BIT + k][0]);
      if (hi != (word[23 - b] ? T1H : T0H)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL single_pixel_high_times: %0d bits wrong, expected 0", bad);
    end
  endtask

  task automatic test_lane_independence();
    int n, fc, bad, hi;
    string d;
    fill_random();
    for (int l = 0; l < 8; l++) mem[0][24 * l +: 24] = 24'h000001 << l;
    run_frame(-1, 1'b0);
    n = frame_errors(fc, d);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL lane_frame: %0d bad cycles, first %0d: %s", n, fc, d);
    end
    bad = 0;
    for (int l = 0; l < 8; l++)
      for (int b = 0; b < 24; b++) begin
        hi = 0;
        for (int k = 0; k < T_BIT; k++) hi += int'(cap_dout[RD_LAT + 1 + b * T_BIT + k][l]);
        if (hi != ((b == 23 - l) ? T1H : T0H)) bad++;
      end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL lane_isolation: %0d lane-bits wrong, expected 0", bad);
    end
  endtask

  task automatic test_full_frame();
    int n, fc, hi_cnt, done_cnt, rd_cnt;
    string d;
    fill_random();
    mem[63] = '1;
    run_frame(-1, 1'b0);
    n = frame_errors(fc, d);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL full_frame: %0d bad cycles, first %0d: %s", n, fc, d);
    end
    hi_cnt = 0;
    done_cnt = 0;
    rd_cnt = 0;
    for (int c = 0; c <= FRAME_LEN; c++) begin
      hi_cnt   += int'(cap_trans[c]);
      done_cnt += int'(cap_done[c]);
      rd_cnt   += int'(cap_rden[c]);
    end
    checks++;
    if (hi_cnt !== 15572) begin
      errors++;
      $display("FAIL trans_length: got %0d expected 15572", hi_cnt);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d expected 1", done_cnt);
    end
    checks++;
    if (rd_cnt !== NPIX) begin
      errors++;
      $display("FAIL rd_en_pulses: got %0d expected %0d", rd_cnt, NPIX);
    end
  endtask

  task automatic test_ignored_restart();
    int n, fc;
    string d;
    fill_random();
    run_frame(5000, 1'b1);
    n = frame_errors(fc, d);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL restart_ignored: %0d bad cycles, first %0d: %s", n, fc, d);
    end
    fill_random();
    run_frame(-1, 1'b0);
    n = frame_errors(fc, d);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL back_to_back: %0d bad cycles, first %0d: %s", n, fc, d);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_send();
    test_single_pixel();
    test_lane_independence();
    test_full_frame();
    test_ignored_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_com_rd.md
Name: ram_com_rd

Overview:
- Read-side counterpart of the layer-RAM write controller. It starts on the one-cycle read pulse that the writer issues after a full 8-layer frame.
- It scans RAM addresses 0..63 across all 8 layer RAMs in parallel and serialises each 24-bit pixel word onto 8 NeoPixel (WS2812) data lanes, one lane per layer.
- It drives trans high for the whole frame so the writer rejects host writes during output.

Parameters:
T_BIT, 438, bit period in SCLK cycles (1.25 us at 350 MHz)
T0H, 140, high time of a '0' bit in cycles
T1H, 280, high time of a '1' bit in cycles
T_RST, 17500, latch/reset low time after the frame, in cycles
RD_LAT, 2, RAM read latency: cycles from rd_en/rdaddre to valid rd_data

Ports:
SCLK  input  1  system clock, rising edge
Rst  input  1  asynchronous, active-high reset
read  input  1  frame start pulse, one cycle wide
rdaddre  output  6  RAM read address 0..63, shared by all layers
rd_en  output  1  RAM read enable
rd_data  input  192  layer i word at [24i+23:24i]; bit 23 is sent first (byte2 MSB)
DOUT  output  8  NeoPixel serial data, bit i = layer i
trans  output  1  high from frame start until end of T_RST low time
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Interface: one clock SCLK. Rst is asynchronous and active-high; the clock and reset polarity and synchronicity are fixed.
- All outputs are registered.
- Reset values: state=IDLE, rdaddre=0, rd_en=0, DOUT=8'h00, trans=0, done=0, all counters=0. Rst mid-frame aborts immediately and DOUT drops low. The next frame requires a new read pulse.
- Counters: 16-bit cycle counter, 5-bit bit index (23..0), 6-bit address. Parameters must satisfy 0<T0H<T1H<T_BIT and T_RST<65536.
- IDLE: if read=1, enter FETCH with address 0 and set trans=1 on the next edge. read in any other state is ignored, including the cycle done pulses.
- FETCH, RD_LAT+1 cycles:
  - First cycle: rd_en=1, rdaddre=current address.
  - rd_en is 0 on the remaining cycles.
  - On the last cycle's edge, capture rd_data into 8 parallel 24-bit shift registers, set bit index=23, then go to SEND.
  - DOUT stays low throughout FETCH.
- SEND: each bit lasts exactly T_BIT cycles.
  - Lane i is high for cycles 0..TxH-1 of the bit, where TxH = T1H if the lane's current bit is 1, else T0H. It is low for the rest of the bit.
  - All lanes share the bit timing.
  - After bit 0 completes:
    - address != 63: increment address and go to FETCH.
    - address == 63: go to LATCH.
- Inter-pixel gap: DOUT is low for (T_BIT - TxH) + RD_LAT + 1 cycles. This is well below WS2812 reset detection.
- LATCH: DOUT low for T_RST cycles, then go to IDLE, trans=0 and done=1 for one cycle.
- Address wraps to 0 only via the frame end. rdaddre holds its last value while IDLE.
- Frame length: trans is high for 64*(RD_LAT+1+24*T_BIT)+T_RST cycles.
- Byte order follows the write order: byte2, byte1, byte0 (G, R, B), MSB first. rd_data bits above 24 per lane do not exist; byte3 is never read.
- The read pulse may be launched on the opposite clock edge. It is sampled on the SCLK rising edge and must be at least one cycle wide; a wider pulse starts only one frame.

Test Plan:
Sim params T_BIT=10, T0H=3, T1H=7, T_RST=20, RD_LAT=2; RAM model returns data 2 cycles after rd_en.
- Reset check: assert Rst mid-SEND -> DOUT=0, trans=0, rd_en=0 immediately (async). After release with no read pulse, outputs stay idle for 100 cycles.
- Single pixel timing: lane0 word 24'hA5_00_FF -> DOUT[0] shows 24 bits of 10 cycles each. Bits 1,0,1,0,0,1,0,1, then eight 0s, then eight 1s. High times are 7/3 cycles.
- Full frame: read pulse -> rd_en pulses at addresses 0..63 in order. trans is high exactly 64*243+20=15572 cycles. done pulses once as trans falls.
- Lane independence: per-layer words 24'h000001<<i -> only lane i carries a '1' (7-cycle high), at bit position 23-i for i<8 of pixel 0. All other lanes show '0' timing.
- Ignored restart: second read pulse at cycle 5000 of a frame -> no restart, and frame length is unchanged. A read pulse 1 cycle after done starts a new frame.
- Address boundary: address 63 data 24'hFFFFFF -> last bit followed by 20 low cycles. rdaddre is never driven to 64/0 mid-frame.
